// File: rtl/mcse_sha_arbiter_pkg.sv
// Shared types and constants for the MCSE SHA-256 core arbiter.
package mcse_sha_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN   = 2'd1,
      DRAIN = 2'd2
   } sha_arb_state_e;

   // Requester slots
   localparam int REQ_SECBOOT = 0;
   localparam int REQ_FWAUTH  = 1;
   localparam int REQ_LC      = 2;

   localparam int DEF_NUM_REQ        = 3;
   localparam int DEF_TIMEOUT_CYCLES = 4096;
   localparam int DEF_BLOCK_W        = 512;
   localparam int DEF_DIGEST_W       = 256;

   // Width of an index/counter over n values, never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mcse_sha_arbiter_if.sv
// Requester-side and SHA-core-side bus of the SHA arbiter.
// slave  : arbiter view.
// master : environment view (requesters plus the SHA core).
interface mcse_sha_arbiter_if #(
   parameter int NUM_REQ  = 3,
   parameter int BLOCK_W  = 512,
   parameter int DIGEST_W = 256
);
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*BLOCK_W-1:0] req_block;
   logic [NUM_REQ-1:0]         req_init;
   logic [NUM_REQ-1:0]         req_next;
   logic [NUM_REQ-1:0]         req_sel;
   logic [NUM_REQ-1:0]         gnt;
   logic [NUM_REQ-1:0]         gnt_ready;
   logic [NUM_REQ-1:0]         gnt_digest_valid;
   logic [DIGEST_W-1:0]        gnt_digest;
   logic [NUM_REQ-1:0]         timeout_err;
   logic                       busy;
   logic                       sha_ready;
   logic                       sha_digest_valid;
   logic [DIGEST_W-1:0]        sha_digest;
   logic [BLOCK_W-1:0]         sha_block;
   logic                       sha_init;
   logic                       sha_next;
   logic                       sha_sel;

   modport slave (
      input  req, req_block, req_init, req_next, req_sel,
      input  sha_ready, sha_digest_valid, sha_digest,
      output gnt, gnt_ready, gnt_digest_valid, gnt_digest, timeout_err, busy,
      output sha_block, sha_init, sha_next, sha_sel
   );

   modport master (
      output req, req_block, req_init, req_next, req_sel,
      output sha_ready, sha_digest_valid, sha_digest,
      input  gnt, gnt_ready, gnt_digest_valid, gnt_digest, timeout_err, busy,
      input  sha_block, sha_init, sha_next, sha_sel
   );
endinterface

// File: rtl/mcse_sha_arbiter_rr_pick.sv
// Round-robin first-set picker: lowest set request at or above ptr_i, with wrap.
module mcse_rr_pick #(
   parameter int N     = 3,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_oh_o,
   output logic [PTR_W-1:0] gnt_idx_o,
   output logic             any_o
);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [PTR_W:0] sum;
   logic [PTR_W:0] k_sel;

   // Rotate so ptr_i lands at bit 0, pick the lowest set bit, then unrotate.
   always_comb begin
      req_dbl   = {req_i, req_i} >> ptr_i;
      req_rot   = req_dbl[N-1:0];
      any_o     = |req_rot;
      k_sel     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_rot[k]) k_sel = (PTR_W+1)'(k);
      end
      sum = {1'b0, ptr_i} + k_sel;
      if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
      gnt_idx_o = sum[PTR_W-1:0];
      gnt_oh_o  = '0;
      for (int i = 0; i < N; i++) begin
         gnt_oh_o[i] = any_o && (sum == (PTR_W+1)'(i));
      end
   end

endmodule

// File: rtl/mcse_sha_arbiter.sv
// Session arbiter for the single SHA-256 core shared by secure boot,
// FW authentication and lifecycle protection.
//
// state | meaning
// IDLE  | no owner; grant the next request in round-robin order
// OWN   | owner's init/next/block/sel forwarded to the core; watchdog runs
// DRAIN | grant released; wait for the core to finish before re-arbitrating
module mcse_sha_arbiter
   import mcse_sha_arb_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int BLOCK_W        = DEF_BLOCK_W,
   parameter int DIGEST_W       = DEF_DIGEST_W
) (
   input logic               clk,
   input logic               rst_n,
   mcse_sha_arbiter_if.slave bus
);

   localparam int PTR_W = idx_width(NUM_REQ);
   localparam int WD_W  = idx_width(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

   sha_arb_state_e     state_q;
   logic [NUM_REQ-1:0] owner_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic [NUM_REQ-1:0] timeout_err_q;
   logic [NUM_REQ-1:0] blk_q;
   logic [PTR_W-1:0]   rr_ptr_q;
   logic [PTR_W-1:0]   rr_ptr_d;
   logic [WD_W-1:0]    wd_q;
   logic [BLOCK_W-1:0] block_hold_q;
   logic               sel_hold_q;

   logic [NUM_REQ-1:0] pick_oh;
   logic [PTR_W-1:0]   pick_idx;
   logic               pick_any;

   logic [BLOCK_W-1:0] own_block;
   logic               own_req;
   logic               own_init;
   logic               own_next;
   logic               own_sel;
   logic               in_own;
   logic               fwd_init;
   logic               fwd_next;

   // A requester that timed out stays masked until it drops req.
   mcse_rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req_i     (bus.req & ~blk_q),
      .ptr_i     (rr_ptr_q),
      .gnt_oh_o  (pick_oh),
      .gnt_idx_o (pick_idx),
      .any_o     (pick_any)
   );

   assign rr_ptr_d = (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;

   // One-hot mux of the current owner's request signals.
   always_comb begin
      own_block = '0;
      own_req   = 1'b0;
      own_init  = 1'b0;
      own_next  = 1'b0;
      own_sel   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q[i]) begin
            own_block = bus.req_block[i*BLOCK_W +: BLOCK_W];
            own_req   = bus.req[i];
            own_init  = bus.req_init[i];
            own_next  = bus.req_next[i];
            own_sel   = bus.req_sel[i];
         end
      end
   end

   assign in_own   = (state_q == OWN);
   assign fwd_init = in_own & own_init;
   assign fwd_next = in_own & own_next & ~own_init;

   // Session FSM with grant, round-robin pointer, watchdog and error flags.
   // The watchdog counts down from TIMEOUT_CYCLES-1 while the core sits ready
   // with no forwarded command; terminal count revokes the grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         owner_q       <= '0;
         gnt_q         <= '0;
         timeout_err_q <= '0;
         blk_q         <= '0;
         rr_ptr_q      <= '0;
         wd_q          <= '0;
         block_hold_q  <= '0;
         sel_hold_q    <= 1'b0;
      end else begin
         blk_q <= blk_q & bus.req;
         unique case (state_q)
            IDLE: begin
               if (pick_any) begin
                  state_q  <= OWN;
                  owner_q  <= pick_oh;
                  gnt_q    <= pick_oh;
                  rr_ptr_q <= rr_ptr_d;
                  wd_q     <= WD_LOAD;
               end
            end
            OWN: begin
               block_hold_q <= own_block;
               sel_hold_q   <= own_sel;
               if (!own_req) begin
                  state_q <= DRAIN;
                  gnt_q   <= '0;
               end else if (fwd_init || fwd_next) begin
                  wd_q <= WD_LOAD;
               end else if (wd_q == '0) begin
                  timeout_err_q <= timeout_err_q | owner_q;
                  blk_q         <= (blk_q & bus.req) | owner_q;
                  gnt_q         <= '0;
                  state_q       <= DRAIN;
               end else if (bus.sha_ready) begin
                  wd_q <= wd_q - 1'b1;
               end
            end
            DRAIN: begin
               if (bus.sha_ready) begin
                  state_q <= IDLE;
                  owner_q <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt              = gnt_q;
   assign bus.timeout_err      = timeout_err_q;
   assign bus.busy             = (state_q != IDLE);
   assign bus.gnt_ready        = gnt_q & {NUM_REQ{bus.sha_ready}};
   assign bus.gnt_digest_valid = gnt_q & {NUM_REQ{bus.sha_digest_valid}};
   assign bus.gnt_digest       = (|gnt_q) ? bus.sha_digest : '0;
   assign bus.sha_init         = fwd_init;
   assign bus.sha_next         = fwd_next;
   assign bus.sha_block        = in_own ? own_block :
                                 (state_q == DRAIN) ? block_hold_q : '0;
   assign bus.sha_sel          = in_own ? own_sel :
                                 (state_q == DRAIN) ? sel_hold_q : 1'b0;

endmodule

// File: tb/tb_mcse_sha_arbiter.sv
// Directed bench for the SHA arbiter, watchdog shortened to 16 cycles.
module tb_mcse_sha_arbiter;

   localparam int NR = 3;
   localparam int BW = 512;
   localparam int DW = 256;

   logic clk;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   logic [BW-1:0] abc_blk;
   logic [DW-1:0] abc_dig;
   logic [BW-1:0] pat0;
   logic [BW-1:0] pat2;
   logic [DW-1:0] dig2;

   mcse_sha_arbiter_if #(.NUM_REQ(NR), .BLOCK_W(BW), .DIGEST_W(DW)) bus ();

   mcse_sha_arbiter #(
      .NUM_REQ        (NR),
      .TIMEOUT_CYCLES (16),
      .BLOCK_W        (BW),
      .DIGEST_W       (DW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic init_inputs();
      bus.req              = '0;
      bus.req_block        = '0;
      bus.req_init         = '0;
      bus.req_next         = '0;
      bus.req_sel          = '0;
      bus.sha_ready        = 1'b1;
      bus.sha_digest_valid = 1'b0;
      bus.sha_digest       = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      init_inputs();
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      init_inputs();
      #1;
      tests++; if (bus.gnt !== 3'b000) begin fails++; $display("FAIL reset_gnt got=%b exp=000", bus.gnt); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      tests++; if (bus.timeout_err !== 3'b000) begin fails++; $display("FAIL reset_terr got=%b exp=000", bus.timeout_err); end
      tests++; if (bus.sha_init !== 1'b0 || bus.sha_next !== 1'b0 || bus.sha_block !== '0) begin
         fails++; $display("FAIL reset_core_out init=%b next=%b", bus.sha_init, bus.sha_next); end
      do_reset();
   endtask

   task automatic test_single();
      step();
      bus.req = 3'b010;
      #1;
      tests++; if (bus.gnt !== 3'b000) begin fails++; $display("FAIL single_latency got=%b exp=000", bus.gnt); end
      step();
      tests++; if (bus.gnt !== 3'b010 || bus.busy !== 1'b1) begin
         fails++; $display("FAIL single_gnt got=%b busy=%b exp=010 busy=1", bus.gnt, bus.busy); end
      bus.req_block[1*BW +: BW] = abc_blk;
      bus.req_init = 3'b010;
      bus.req_sel  = 3'b010;
      #1;
      tests++; if (bus.sha_init !== 1'b1 || bus.sha_next !== 1'b0 || bus.sha_sel !== 1'b1) begin
         fails++; $display("FAIL single_fwd init=%b next=%b sel=%b exp 1 0 1", bus.sha_init, bus.sha_next, bus.sha_sel); end
      tests++; if (bus.sha_block !== abc_blk) begin fails++; $display("FAIL single_block got=%h exp=%h", bus.sha_block, abc_blk); end
      step();
      bus.req_init  = '0;
      bus.sha_ready = 1'b0;
      #1;
      tests++; if (bus.gnt_ready !== 3'b000 || bus.sha_init !== 1'b0) begin
         fails++; $display("FAIL single_busy gnt_ready=%b init=%b exp 000 0", bus.gnt_ready, bus.sha_init); end
      step();
      step();
      bus.sha_ready        = 1'b1;
      bus.sha_digest_valid = 1'b1;
      bus.sha_digest       = abc_dig;
      #1;
      tests++; if (bus.gnt_digest_valid !== 3'b010 || bus.gnt_ready !== 3'b010) begin
         fails++; $display("FAIL single_dv dv=%b rdy=%b exp 010 010", bus.gnt_digest_valid, bus.gnt_ready); end
      tests++; if (bus.gnt_digest !== abc_dig) begin fails++; $display("FAIL single_digest got=%h exp=%h", bus.gnt_digest, abc_dig); end
      step();
      bus.sha_digest_valid = 1'b0;
      bus.req = '0;
      step();
      bus.req_block = '0;
      #1;
      tests++; if (bus.gnt !== 3'b000 || bus.busy !== 1'b1 || bus.gnt_digest !== '0) begin
         fails++; $display("FAIL single_drain gnt=%b busy=%b exp 000 1", bus.gnt, bus.busy); end
      tests++; if (bus.sha_block !== abc_blk) begin fails++; $display("FAIL single_hold got=%h exp=%h", bus.sha_block, abc_blk); end
      step();
      tests++; if (bus.busy !== 1'b0 || bus.sha_block !== '0) begin
         fails++; $display("FAIL single_idle busy=%b exp=0", bus.busy); end
   endtask

   task automatic test_contention();
      do_reset();
      bus.req = 3'b111;
      step();
      tests++; if (bus.gnt !== 3'b001) begin fails++; $display("FAIL cont_first got=%b exp=001", bus.gnt); end
      bus.req = 3'b110;
      step();
      tests++; if (bus.gnt !== 3'b000 || bus.busy !== 1'b1) begin
         fails++; $display("FAIL cont_drain1 gnt=%b busy=%b exp 000 1", bus.gnt, bus.busy); end
      step();
      tests++; if (bus.gnt !== 3'b000 || bus.busy !== 1'b0) begin
         fails++; $display("FAIL cont_idle1 gnt=%b busy=%b exp 000 0", bus.gnt, bus.busy); end
      step();
      tests++; if (bus.gnt !== 3'b010) begin fails++; $display("FAIL cont_second got=%b exp=010", bus.gnt); end
      bus.req       = 3'b100;
      bus.sha_ready = 1'b0;
      step();
      step();
      tests++; if (bus.gnt !== 3'b000 || bus.busy !== 1'b1) begin
         fails++; $display("FAIL cont_drain_wait gnt=%b busy=%b exp 000 1", bus.gnt, bus.busy); end
      bus.sha_ready = 1'b1;
      step();
      step();
      tests++; if (bus.gnt !== 3'b100) begin fails++; $display("FAIL cont_third got=%b exp=100", bus.gnt); end
      bus.req = '0;
      step();
      step();
   endtask

   task automatic test_isolation();
      do_reset();
      bus.req = 3'b001;
      step();
      bus.req_block[0*BW +: BW] = pat0;
      bus.req_block[2*BW +: BW] = pat2;
      bus.req_init             = 3'b100;
      bus.req_sel              = 3'b100;
      bus.sha_digest_valid     = 1'b1;
      bus.sha_digest           = dig2;
      #1;
      tests++; if (bus.sha_init !== 1'b0 || bus.sha_sel !== 1'b0) begin
         fails++; $display("FAIL iso_init init=%b sel=%b exp 0 0", bus.sha_init, bus.sha_sel); end
      tests++; if (bus.sha_block !== pat0) begin fails++; $display("FAIL iso_block got=%h exp=%h", bus.sha_block, pat0); end
      tests++; if (bus.gnt_ready !== 3'b001 || bus.gnt_digest_valid !== 3'b001) begin
         fails++; $display("FAIL iso_route rdy=%b dv=%b exp 001 001", bus.gnt_ready, bus.gnt_digest_valid); end
      step();
      bus.req_init         = 3'b001;
      bus.req_next         = 3'b001;
      bus.req_sel          = '0;
      bus.sha_digest_valid = 1'b0;
      #1;
      tests++; if (bus.sha_init !== 1'b1 || bus.sha_next !== 1'b0) begin
         fails++; $display("FAIL collide init=%b next=%b exp 1 0", bus.sha_init, bus.sha_next); end
      step();
      bus.req_init = '0;
      #1;
      tests++; if (bus.sha_init !== 1'b0 || bus.sha_next !== 1'b1) begin
         fails++; $display("FAIL next_only init=%b next=%b exp 0 1", bus.sha_init, bus.sha_next); end
      step();
      bus.req_next = '0;
      bus.req      = '0;
      step();
      step();
   endtask

   task automatic test_watchdog();
      do_reset();
      bus.req = 3'b100;
      step();
      repeat (15) step();
      tests++; if (bus.gnt !== 3'b100 || bus.timeout_err !== 3'b000) begin
         fails++; $display("FAIL wd_before gnt=%b terr=%b exp 100 000", bus.gnt, bus.timeout_err); end
      step();
      tests++; if (bus.gnt !== 3'b000 || bus.timeout_err !== 3'b100 || bus.busy !== 1'b1) begin
         fails++; $display("FAIL wd_fire gnt=%b terr=%b busy=%b exp 000 100 1", bus.gnt, bus.timeout_err, bus.busy); end
      step();
      step();
      step();
      tests++; if (bus.gnt !== 3'b000 || bus.busy !== 1'b0) begin
         fails++; $display("FAIL wd_blocked gnt=%b busy=%b exp 000 0", bus.gnt, bus.busy); end
      bus.req = 3'b101;
      step();
      tests++; if (bus.gnt !== 3'b001) begin fails++; $display("FAIL wd_other got=%b exp=001", bus.gnt); end
      bus.req = 3'b100;
      step();
      step();
      step();
      tests++; if (bus.gnt !== 3'b000) begin fails++; $display("FAIL wd_still_blocked got=%b exp=000", bus.gnt); end
      bus.req = 3'b000;
      step();
      bus.req = 3'b100;
      step();
      tests++; if (bus.gnt !== 3'b100 || bus.timeout_err !== 3'b100) begin
         fails++; $display("FAIL wd_regrant gnt=%b terr=%b exp 100 100", bus.gnt, bus.timeout_err); end
      bus.req = '0;
      step();
      step();
   endtask

   task automatic test_reset_mid();
      bus.req = 3'b010;
      bus.req_block[1*BW +: BW] = abc_blk;
      step();
      tests++; if (bus.gnt !== 3'b010) begin fails++; $display("FAIL mid_gnt got=%b exp=010", bus.gnt); end
      bus.sha_ready = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      tests++; if (bus.gnt !== 3'b000 || bus.busy !== 1'b0 || bus.timeout_err !== 3'b000) begin
         fails++; $display("FAIL mid_async gnt=%b busy=%b terr=%b exp 000 0 000", bus.gnt, bus.busy, bus.timeout_err); end
      tests++; if (bus.sha_block !== '0) begin fails++; $display("FAIL mid_block got=%h exp=0", bus.sha_block); end
      step();
      rst_n = 1'b1;
      bus.sha_ready = 1'b1;
      #1;
      step();
      tests++; if (bus.gnt !== 3'b010) begin fails++; $display("FAIL mid_regrant got=%b exp=010", bus.gnt); end
   endtask

   initial begin
      abc_blk = {32'h6162_6380, 416'h0, 64'h18};
      abc_dig = 256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;
      pat0    = {16{32'hA5A5_0000}};
      pat2    = {16{32'h1234_5678}};
      dig2    = {8{32'hDEAD_BEEF}};
      test_reset();
      test_single();
      test_contention();
      test_isolation();
      test_watchdog();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
